// File: rtl/rf_arbiter.sv
`timescale 1ns/1ps
// Two-requester round-robin front end for an 8-bit x 16 register file.
// Optional grant locking is compiled in with RF_ARB_LOCK_EN.
module rf_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req0_we,
  input  logic [3:0] req0_addr,
  input  logic [7:0] req0_wdata,
  input  logic       req0_lock,
  output logic       req0_ready,
  output logic       req0_rvalid,
  output logic [7:0] req0_rdata,
  input  logic       req1_valid,
  input  logic       req1_we,
  input  logic [3:0] req1_addr,
  input  logic [7:0] req1_wdata,
  input  logic       req1_lock,
  output logic       req1_ready,
  output logic       req1_rvalid,
  output logic [7:0] req1_rdata,
  output logic       rf_we,
  output logic [3:0] rf_ptr_w,
  output logic [7:0] rf_di,
  output logic [3:0] rf_ptr_a,
  input  logic [7:0] rf_do_a,
  output logic       err,
  input  logic       err_clr
);

  logic       rr;
  logic       pri;
  logic       gnt0;
  logic       gnt1;
  logic       acc;
  logic       sel_we;
  logic [3:0] sel_addr;
  logic [7:0] sel_wdata;
  logic       wr_ok;
  logic       wr_rsv;
  logic       rd_acc;

`ifdef RF_ARB_LOCK_EN
  logic       sel_lock;
  logic       lock_hold;
  logic       lock_owner;
  logic [1:0] lock_cnt;

  assign sel_lock = gnt1 ? req1_lock : req0_lock;
  assign pri      = lock_hold ? lock_owner : rr;
`else
  logic unused_lock;

  assign unused_lock = req0_lock ^ req1_lock;
  assign pri         = rr;
`endif

  // Grants are masked by reset so nothing is accepted while rst_n is low.
  always_comb begin
    gnt0 = rst_n & req0_valid & (~req1_valid | ~pri);
    gnt1 = rst_n & req1_valid & (~req0_valid | pri);
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign acc        = gnt0 | gnt1;

  always_comb begin
    sel_we    = gnt1 ? req1_we    : req0_we;
    sel_addr  = gnt1 ? req1_addr  : req0_addr;
    sel_wdata = gnt1 ? req1_wdata : req0_wdata;
  end

  // Addresses 14 and 15 are reserved: accepted, never written, flagged.
  always_comb begin
    wr_rsv   = acc & sel_we & (sel_addr >= 4'd14);
    wr_ok    = acc & sel_we & (sel_addr < 4'd14);
    rd_acc   = acc & ~sel_we;
    rf_we    = wr_ok;
    rf_ptr_w = wr_ok  ? sel_addr  : 4'd0;
    rf_di    = wr_ok  ? sel_wdata : 8'd0;
    rf_ptr_a = rd_acc ? sel_addr  : 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= 1'b0;
    end else if (acc) begin
      rr <= gnt0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      req0_rdata  <= 8'h00;
      req1_rdata  <= 8'h00;
    end else begin
      req0_rvalid <= rd_acc & gnt0;
      req1_rvalid <= rd_acc & gnt1;
      if (rd_acc & gnt0) req0_rdata <= rf_do_a;
      if (rd_acc & gnt1) req1_rdata <= rf_do_a;
    end
  end

  // A new reserved write outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (wr_rsv) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

`ifdef RF_ARB_LOCK_EN
  // lock_cnt counts grants in the current chain; the fourth one releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_hold  <= 1'b0;
      lock_owner <= 1'b0;
      lock_cnt   <= 2'd0;
    end else if (acc && sel_lock) begin
      if (lock_hold && (gnt1 == lock_owner)) begin
        if (lock_cnt == 2'd3) begin
          lock_hold <= 1'b0;
          lock_cnt  <= 2'd0;
        end else begin
          lock_cnt  <= lock_cnt + 2'd1;
        end
      end else begin
        lock_hold  <= 1'b1;
        lock_owner <= gnt1;
        lock_cnt   <= 2'd1;
      end
    end else begin
      lock_hold <= 1'b0;
      lock_cnt  <= 2'd0;
    end
  end
`endif

endmodule
